// File: rtl/pc_sequencer.sv
// Fetch program counter sequencer: selects next PC (sequential, branch target, stall hold, halt freeze)
// and raises pipeline flush strobes on redirect. Optional counters under PC_SEQUENCER_PERFCNT_EN.
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Halt,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        ALUZero,
  input  logic [63:0] BranchPC,
  input  logic [63:0] SignExtImm64,
  output logic [63:0] PC,
  output logic        FetchValid,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        EXMEMFlush,
`ifdef PC_SEQUENCER_PERFCNT_EN
  output logic [31:0] TakenCount,
  output logic [31:0] StallCount,
`endif
  output logic        Halted
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        taken;
  logic        redirect;
  logic [63:0] target;

  assign taken    = Uncondbranch | (Branch & ALUZero);
  assign target   = BranchPC + (SignExtImm64 << 2);
  assign redirect = taken && (state_q != BOOT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN, STALL: begin
        if (taken) begin
          pc_d    = target;
          state_d = RUN;
        end else if (Halt) begin
          state_d = HALT;
        end else if (Stall) begin
          state_d = STALL;
        end else begin
          pc_d    = pc_q + PC_STEP;
          state_d = RUN;
        end
      end
      HALT: begin
        if (taken) begin
          pc_d    = target;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign PC         = pc_q;
  assign FetchValid = (state_q == RUN) || (state_q == STALL);
  assign Halted     = (state_q == HALT);
  // Reset gates the strobes so a reset cycle never clears pipeline registers on its own.
  assign IFIDFlush  = redirect & ~Reset;
  assign IDEXFlush  = redirect & ~Reset;
  assign EXMEMFlush = redirect & ~Reset;

`ifdef PC_SEQUENCER_PERFCNT_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (redirect && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + 32'd1;
    if ((state_q == STALL) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign TakenCount = taken_cnt_q;
  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_PC = 64'h100).
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        Reset, Stall, Halt, Branch, Uncondbranch, ALUZero;
  logic [63:0] BranchPC, SignExtImm64;
  logic [63:0] PC;
  logic        FetchValid, IFIDFlush, IDEXFlush, EXMEMFlush, Halted;
`ifdef PC_SEQUENCER_PERFCNT_EN
  logic [31:0] TakenCount, StallCount;
`endif

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  pc_sequencer #(.RESET_PC(64'h100), .PC_STEP(64'd4)) dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .Halt(Halt), .Branch(Branch),
    .Uncondbranch(Uncondbranch), .ALUZero(ALUZero), .BranchPC(BranchPC),
    .SignExtImm64(SignExtImm64), .PC(PC), .FetchValid(FetchValid),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush),
`ifdef PC_SEQUENCER_PERFCNT_EN
    .TakenCount(TakenCount), .StallCount(StallCount),
`endif
    .Halted(Halted)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Reset = 0; Stall = 0; Halt = 0; Branch = 0; Uncondbranch = 0; ALUZero = 0;
    BranchPC = '0; SignExtImm64 = '0;
  endtask

  // Redirect unconditionally to an absolute address (imm = 0).
  task automatic jump_to(input logic [63:0] addr);
    idle();
    Uncondbranch = 1; BranchPC = addr;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    Reset = 1; Uncondbranch = 1; BranchPC = 64'h900;
    tick(); tick();
    #1;
    total_cnt++; if (PC !== 64'h100) $display("FAIL reset_pc got %h want %h", PC, 64'h100); else pass_cnt++;
    total_cnt++; if (FetchValid !== 1'b0) $display("FAIL reset_fv got %b want 0", FetchValid); else pass_cnt++;
    total_cnt++; if (Halted !== 1'b0) $display("FAIL reset_halted got %b want 0", Halted); else pass_cnt++;
    total_cnt++; if ({IFIDFlush, IDEXFlush, EXMEMFlush} !== 3'b000)
      $display("FAIL reset_flush got %b want 000", {IFIDFlush, IDEXFlush, EXMEMFlush}); else pass_cnt++;
    // Release reset; BOOT cycle with a taken branch that must be ignored.
    Reset = 0; Uncondbranch = 1; BranchPC = 64'h500;
    #1;
    total_cnt++; if ({IFIDFlush, IDEXFlush, EXMEMFlush} !== 3'b000)
      $display("FAIL boot_flush got %b want 000", {IFIDFlush, IDEXFlush, EXMEMFlush}); else pass_cnt++;
    total_cnt++; if (FetchValid !== 1'b0) $display("FAIL boot_fv got %b want 0", FetchValid); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (PC !== 64'h100) $display("FAIL boot_pc got %h want %h", PC, 64'h100); else pass_cnt++;
    total_cnt++; if (FetchValid !== 1'b1) $display("FAIL run_fv got %b want 1", FetchValid); else pass_cnt++;
    tick();
    total_cnt++; if (PC !== 64'h104) $display("FAIL seq1 got %h want %h", PC, 64'h104); else pass_cnt++;
    tick();
    total_cnt++; if (PC !== 64'h108) $display("FAIL seq2 got %h want %h", PC, 64'h108); else pass_cnt++;
  endtask

  task automatic test_redirect();
    idle();
    Uncondbranch = 1; BranchPC = 64'h100; SignExtImm64 = 64'h10;
    #1;
    total_cnt++; if ({IFIDFlush, IDEXFlush, EXMEMFlush} !== 3'b111)
      $display("FAIL uncond_flush got %b want 111", {IFIDFlush, IDEXFlush, EXMEMFlush}); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (PC !== 64'h140) $display("FAIL uncond_pc got %h want %h", PC, 64'h140); else pass_cnt++;
    total_cnt++; if (FetchValid !== 1'b1) $display("FAIL uncond_fv got %b want 1", FetchValid); else pass_cnt++;
  endtask

  task automatic test_cond_branch();
    idle();
    Branch = 1; ALUZero = 0; BranchPC = 64'h700; SignExtImm64 = 64'h3;
    #1;
    total_cnt++; if (IFIDFlush !== 1'b0) $display("FAIL nottaken_flush got %b want 0", IFIDFlush); else pass_cnt++;
    tick();
    total_cnt++; if (PC !== 64'h144) $display("FAIL nottaken_pc got %h want %h", PC, 64'h144); else pass_cnt++;
    Branch = 1; ALUZero = 1; BranchPC = 64'h200; SignExtImm64 = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    total_cnt++; if ({IFIDFlush, IDEXFlush, EXMEMFlush} !== 3'b111)
      $display("FAIL cbz_flush got %b want 111", {IFIDFlush, IDEXFlush, EXMEMFlush}); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (PC !== 64'h1F8) $display("FAIL cbz_pc got %h want %h", PC, 64'h1F8); else pass_cnt++;
  endtask

  task automatic test_stall();
    jump_to(64'h120);
    total_cnt++; if (PC !== 64'h120) $display("FAIL stall_setup got %h want %h", PC, 64'h120); else pass_cnt++;
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (PC !== 64'h120) $display("FAIL stall_hold%0d got %h want %h", i, PC, 64'h120); else pass_cnt++;
      total_cnt++; if (FetchValid !== 1'b1) $display("FAIL stall_fv%0d got %b want 1", i, FetchValid); else pass_cnt++;
    end
    Stall = 0;
    tick();
    total_cnt++; if (PC !== 64'h124) $display("FAIL stall_release got %h want %h", PC, 64'h124); else pass_cnt++;
    Stall = 1; Uncondbranch = 1; BranchPC = 64'h300; SignExtImm64 = 64'h1;
    #1;
    total_cnt++; if ({IFIDFlush, IDEXFlush, EXMEMFlush} !== 3'b111)
      $display("FAIL stall_taken_flush got %b want 111", {IFIDFlush, IDEXFlush, EXMEMFlush}); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (PC !== 64'h304) $display("FAIL stall_taken_pc got %h want %h", PC, 64'h304); else pass_cnt++;
    tick();
    total_cnt++; if (PC !== 64'h308) $display("FAIL stall_taken_run got %h want %h", PC, 64'h308); else pass_cnt++;
  endtask

  task automatic test_halt();
    jump_to(64'h130);
    Halt = 1;
    tick();
    Halt = 0; Stall = 1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (PC !== 64'h130) $display("FAIL halt_pc%0d got %h want %h", i, PC, 64'h130); else pass_cnt++;
      total_cnt++; if ({Halted, FetchValid} !== 2'b10)
        $display("FAIL halt_flags%0d got %b want 10", i, {Halted, FetchValid}); else pass_cnt++;
      Halt = (i % 2 == 0);
      tick();
    end
    idle();
    Uncondbranch = 1; BranchPC = 64'h80;
    #1;
    total_cnt++; if (IFIDFlush !== 1'b1) $display("FAIL halt_exit_flush got %b want 1", IFIDFlush); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (PC !== 64'h80) $display("FAIL halt_exit_pc got %h want %h", PC, 64'h80); else pass_cnt++;
    total_cnt++; if ({Halted, FetchValid} !== 2'b01)
      $display("FAIL halt_exit_flags got %b want 01", {Halted, FetchValid}); else pass_cnt++;
    Stall = 1;
    tick();
    Reset = 1;
    tick();
    total_cnt++; if (PC !== 64'h100) $display("FAIL stall_reset_pc got %h want %h", PC, 64'h100); else pass_cnt++;
    total_cnt++; if (FetchValid !== 1'b0) $display("FAIL stall_reset_fv got %b want 0", FetchValid); else pass_cnt++;
    idle();
    tick();
    tick();
    total_cnt++; if (PC !== 64'h104) $display("FAIL post_reset_pc got %h want %h", PC, 64'h104); else pass_cnt++;
  endtask

  task automatic test_wrap();
    jump_to(64'hFFFF_FFFF_FFFF_FFFC);
    total_cnt++; if (PC !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_setup got %h", PC); else pass_cnt++;
    tick();
    total_cnt++; if (PC !== 64'h0) $display("FAIL seq_wrap got %h want %h", PC, 64'h0); else pass_cnt++;
    Uncondbranch = 1; BranchPC = 64'hFFFF_FFFF_FFFF_FFF0; SignExtImm64 = 64'h8;
    tick();
    idle();
    total_cnt++; if (PC !== 64'h10) $display("FAIL target_wrap got %h want %h", PC, 64'h10); else pass_cnt++;
  endtask

`ifdef PC_SEQUENCER_PERFCNT_EN
  task automatic test_perfcnt();
    idle();
    Reset = 1;
    tick();
    total_cnt++; if ({TakenCount, StallCount} !== 64'h0)
      $display("FAIL cnt_reset got %h/%h want 0/0", TakenCount, StallCount); else pass_cnt++;
    idle();
    tick();
    jump_to(64'h400);
    jump_to(64'h500);
    Stall = 1;
    tick(); tick(); tick();
    Stall = 0;
    tick();
    total_cnt++; if (TakenCount !== 32'd2) $display("FAIL taken_count got %0d want 2", TakenCount); else pass_cnt++;
    total_cnt++; if (StallCount !== 32'd3) $display("FAIL stall_count got %0d want 3", StallCount); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_redirect();
    test_cond_branch();
    test_stall();
    test_halt();
    test_wrap();
`ifdef PC_SEQUENCER_PERFCNT_EN
    test_perfcnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
